// File: rtl/residu_filt.sv
// residu_filt: LPC analysis filter A(z). For one subframe it computes
// e(n) = sum a(j)*x(n-j), j=0..M, with G.729 Residu arithmetic
// (L_mult/L_mac, L_shl by 3, round). It reads operands from and writes
// results to a shared 32-bit scratch memory.
// Optional feature macro: RESIDU_OVF_FLAG_EN adds a sticky saturation flag port.
module residu_filt #(
  parameter int M  = 10,
  parameter int LG = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] aAddr,
  input  logic [10:0] xAddr,
  input  logic [10:0] yAddr,
  input  logic [31:0] memIn,
  output logic [10:0] memReadAddr,
  output logic [10:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic        busy,
  output logic        done
`ifdef RESIDU_OVF_FLAG_EN
  ,
  output logic        overflow
`endif
);

  localparam int CW = $clog2(M + 2);
  localparam int IW = $clog2(LG + 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, MAC, WRITE, FIN} stateT;

  stateT           stateReg, stateNext;
  logic [CW-1:0]   cntReg;
  logic [IW-1:0]   iReg;
  logic [31:0]     sReg;
  logic [10:0]     aBaseReg, xBaseReg, yBaseReg;
  logic [10:0]     rdHoldReg;
  logic [15:0]     cA [0:M];

  logic            reading;
  logic [10:0]     rdAddrNow;
  logic            accepting;
  logic            accumulating;

  // Arithmetic datapath signals
  logic [CW-1:0]   coefIdx;
  logic [15:0]     coefOp, xOp;
  logic signed [31:0] coefExt, xExt, prod;
  logic            multSat;
  logic [31:0]     lMult;
  logic [32:0]     macSum;
  logic            macOvf;
  logic [31:0]     macSat;
  logic [31:0]     accNext;
  logic            shlOvf;
  logic [31:0]     shlVal;
  logic [32:0]     rndSum;
  logic            rndOvf;
  logic [15:0]     rndVal;
  logic            unusedBits;

  // Coefficient register file: cA[gi] is loaded the cycle after aAddr+gi is read
  genvar gi;
  generate
    for (gi = 0; gi <= M; gi++) begin : gCoef
      logic [15:0] coefReg;
      // Capture coefficient gi when its read data is on memIn
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          coefReg <= '0;
        end else if (stateReg == LOAD_A && cntReg == CW'(gi + 1)) begin
          coefReg <= memIn[15:0];
        end
      end
      assign cA[gi] = coefReg;
    end
  endgenerate

  assign accepting    = (stateReg == IDLE) && start;
  assign accumulating = (stateReg == MAC) && (cntReg != '0);

  // Read address for the current cycle; only meaningful while reading
  assign rdAddrNow = (stateReg == LOAD_A) ? aBaseReg + 11'(cntReg)
                                          : xBaseReg + 11'(iReg) - 11'(cntReg);

  // L_mult / L_mac: cycle k+1 of MAC multiplies cA[k] by the x read at cycle k
  assign coefIdx = (cntReg == '0) ? '0 : cntReg - 1'b1;
  assign coefOp  = cA[coefIdx];
  assign xOp     = memIn[15:0];
  assign coefExt = {{16{coefOp[15]}}, coefOp};
  assign xExt    = {{16{xOp[15]}}, xOp};
  assign prod    = coefExt * xExt;
  assign multSat = (coefOp == 16'h8000) && (xOp == 16'h8000);
  assign lMult   = multSat ? 32'h7FFF_FFFF : {prod[30:0], 1'b0};
  assign macSum  = {sReg[31], sReg} + {lMult[31], lMult};
  assign macOvf  = macSum[32] ^ macSum[31];
  assign macSat  = macOvf ? (macSum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : macSum[31:0];
  assign accNext = (cntReg == CW'(1)) ? lMult : macSat;

  // L_shl(s,3) saturates when any of the three shifted-out bits differ from the sign
  assign shlOvf = (sReg[31:28] != 4'h0) && (sReg[31:28] != 4'hF);
  assign shlVal = shlOvf ? (sReg[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : {sReg[28:0], 3'b000};
  // round: only positive overflow is possible when adding 0x8000
  assign rndSum = {shlVal[31], shlVal} + 33'h0_0000_8000;
  assign rndOvf = rndSum[32] ^ rndSum[31];
  assign rndVal = rndOvf ? 16'h7FFF : rndSum[31:16];

  assign unusedBits = &{1'b0, memIn[31:16], prod[31], rndSum[15:0]};

  // Next-state logic and memory/handshake outputs
  always_comb begin
    stateNext    = stateReg;
    reading      = 1'b0;
    memWriteEn   = 1'b0;
    memWriteAddr = '0;
    memOut       = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) stateNext = LOAD_A;
      end
      LOAD_A: begin
        busy    = 1'b1;
        reading = (cntReg <= CW'(M));
        if (cntReg == CW'(M + 1)) stateNext = MAC;
      end
      MAC: begin
        busy    = 1'b1;
        reading = (cntReg <= CW'(M));
        if (cntReg == CW'(M + 1)) stateNext = WRITE;
      end
      WRITE: begin
        busy         = 1'b1;
        memWriteEn   = 1'b1;
        memWriteAddr = yBaseReg + 11'(iReg);
        memOut       = {{16{rndVal[15]}}, rndVal};
        stateNext    = (iReg == IW'(LG - 1)) ? FIN : MAC;
      end
      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // The read port shows the live address while reading, else the last one issued
  assign memReadAddr = reading ? rdAddrNow : rdHoldReg;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  // Per-phase cycle counter, restarted on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntReg <= '0;
    end else if (stateNext != stateReg) begin
      cntReg <= '0;
    end else if (stateReg == LOAD_A || stateReg == MAC) begin
      cntReg <= cntReg + 1'b1;
    end
  end

  // Run context: base addresses, sample index, accumulator, held read address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aBaseReg  <= '0;
      xBaseReg  <= '0;
      yBaseReg  <= '0;
      iReg      <= '0;
      sReg      <= '0;
      rdHoldReg <= '0;
    end else begin
      if (accepting) begin
        aBaseReg <= aAddr;
        xBaseReg <= xAddr;
        yBaseReg <= yAddr;
        iReg     <= '0;
      end else if (stateReg == WRITE) begin
        iReg <= iReg + 1'b1;
      end
      if (accumulating) sReg <= accNext;
      if (reading) rdHoldReg <= rdAddrNow;
    end
  end

`ifdef RESIDU_OVF_FLAG_EN
  logic ovfReg;
  logic accOvf;
  assign accOvf   = multSat || ((cntReg != CW'(1)) && macOvf);
  assign overflow = ovfReg;

  // Sticky saturation flag, cleared by an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovfReg <= 1'b0;
    end else if (accepting) begin
      ovfReg <= 1'b0;
    end else if ((accumulating && accOvf) || (stateReg == WRITE && (shlOvf || rndOvf))) begin
      ovfReg <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_residu_filt.sv
// tb_residu_filt: directed self-checking bench for residu_filt.
// Cycle n is the clock period following rising edge n; start is sampled at edge 0.
`timescale 1ns/1ps
module tb_residu_filt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] aAddr = '0, xAddr = '0, yAddr = '0;
  logic [31:0] memIn = '0;
  logic [10:0] memReadAddr, memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn, busy, done;
`ifdef RESIDU_OVF_FLAG_EN
  logic        overflow;
`endif

  residu_filt dut (
    .clk(clk), .reset(reset), .start(start),
    .aAddr(aAddr), .xAddr(xAddr), .yAddr(yAddr),
    .memIn(memIn), .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
    .memOut(memOut), .memWriteEn(memWriteEn), .busy(busy), .done(done)
`ifdef RESIDU_OVF_FLAG_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // Scratch memory: registered read, one cycle latency
  logic [31:0] mem [0:2047];
  always @(posedge clk) memIn <= mem[memReadAddr];

  int cmpCount = 0;
  int errCount = 0;

  // Observations of one run
  int          wrCount, doneCount, doneCyc, busyErr;
  int          wrCyc  [64];
  logic [10:0] wrAddr [64];
  logic [31:0] wrData [64];

  task automatic setW(input int addr, input int v);
    mem[11'(addr)] = {16'hA5A5, 16'(v)};
  endtask

  task automatic loadA(input int base, input int c[11]);
    for (int k = 0; k < 11; k++) setW(base + k, c[k]);
  endtask

  // Start a run and observe 545 cycles; extra start pulses are driven after cycles p1/p2
  task automatic doRun(input int aB, input int xB, input int yB, input int p1, input int p2);
    wrCount = 0; doneCount = 0; doneCyc = -1; busyErr = 0;
    for (int k = 0; k < 64; k++) begin
      wrCyc[k] = -1; wrAddr[k] = 'x; wrData[k] = 'x;
    end
    @(negedge clk);
    aAddr = 11'(aB); xAddr = 11'(xB); yAddr = 11'(yB); start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 545; n++) begin
      @(negedge clk);
      if (memWriteEn === 1'b1) begin
        if (wrCount < 64) begin
          wrCyc[wrCount] = n; wrAddr[wrCount] = memWriteAddr; wrData[wrCount] = memOut;
        end
        wrCount++;
      end
      if (done === 1'b1) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = n;
      end
      if (busy !== (n >= 1 && n <= 532)) busyErr++;
      start = (n == p1 || n == p2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    cmpCount++; if (memReadAddr !== 11'd0) begin errCount++; $display("FAIL reset_memReadAddr: got %0d want 0", memReadAddr); end
    cmpCount++; if (memWriteAddr !== 11'd0) begin errCount++; $display("FAIL reset_memWriteAddr: got %0d want 0", memWriteAddr); end
    cmpCount++; if (memOut !== 32'd0) begin errCount++; $display("FAIL reset_memOut: got %h want 0", memOut); end
    cmpCount++; if (memWriteEn !== 1'b0) begin errCount++; $display("FAIL reset_memWriteEn: got %b want 0", memWriteEn); end
    cmpCount++; if (busy !== 1'b0) begin errCount++; $display("FAIL reset_busy: got %b want 0", busy); end
    cmpCount++; if (done !== 1'b0) begin errCount++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef RESIDU_OVF_FLAG_EN
    cmpCount++; if (overflow !== 1'b0) begin errCount++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmpCount++; if (busy !== 1'b0) begin errCount++; $display("FAIL idle_busy: got %b want 0", busy); end
    $display("reset: outputs checked in and after reset");
  endtask

  task automatic setupIdentity(input int aB, input int xB);
    loadA(aB, '{4096, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 40; i++) setW(xB + i, i - 20);
    for (int k = 1; k <= 10; k++) setW(xB - k, 0);
  endtask

  task automatic test_identity();
    logic [31:0] e;
    setupIdentity(100, 300);
    doRun(100, 300, 600, 0, 0);
    cmpCount++; if (wrCount !== 40) begin errCount++; $display("FAIL identity_writes: got %0d want 40", wrCount); end
    cmpCount++; if (doneCyc !== 533) begin errCount++; $display("FAIL identity_done_cycle: got %0d want 533", doneCyc); end
    for (int k = 0; k < 40; k++) begin
      e = k - 20;
      cmpCount++; if (wrData[k] !== e) begin errCount++; $display("FAIL identity_y%0d: got %h want %h", k, wrData[k], e); end
    end
`ifdef RESIDU_OVF_FLAG_EN
    cmpCount++; if (overflow !== 1'b0) begin errCount++; $display("FAIL identity_overflow: got %b want 0", overflow); end
`endif
    $display("identity: %0d writes, done at cycle %0d", wrCount, doneCyc);
  endtask

  task automatic test_difference();
    loadA(120, '{4096, -4096, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 40; i++) setW(320 + i, 3 * i);
    setW(319, -3);
    for (int k = 2; k <= 10; k++) setW(320 - k, 1234 * k);
    doRun(120, 320, 640, 0, 0);
    cmpCount++; if (wrCount !== 40) begin errCount++; $display("FAIL diff_writes: got %0d want 40", wrCount); end
    for (int k = 0; k < 40; k++) begin
      cmpCount++; if (wrData[k] !== 32'd3) begin errCount++; $display("FAIL diff_y%0d: got %h want 00000003", k, wrData[k]); end
    end
    $display("difference: %0d writes, y[0]=%h", wrCount, wrData[0]);
  endtask

  task automatic test_saturation();
    logic [31:0] e;
    // All operands at full scale: L_mac, L_shl and round all saturate
    loadA(140, '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767});
    for (int i = -10; i < 40; i++) setW(400 + i, 32767);
    doRun(140, 400, 700, 0, 0);
    cmpCount++; if (wrCount !== 40) begin errCount++; $display("FAIL satpos_writes: got %0d want 40", wrCount); end
    for (int k = 0; k < 40; k++) begin
      cmpCount++; if (wrData[k] !== 32'h0000_7FFF) begin errCount++; $display("FAIL satpos_y%0d: got %h want 00007fff", k, wrData[k]); end
    end
`ifdef RESIDU_OVF_FLAG_EN
    cmpCount++; if (overflow !== 1'b1) begin errCount++; $display("FAIL satpos_overflow: got %b want 1", overflow); end
`endif
    $display("saturation full-scale: y[0]=%h", wrData[0]);

    // Most negative input through unity gain: exact, no saturation
    loadA(160, '{4096, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = -10; i < 40; i++) setW(400 + i, -32768);
    doRun(160, 400, 700, 0, 0);
    for (int k = 0; k < 40; k++) begin
      cmpCount++; if (wrData[k] !== 32'hFFFF_8000) begin errCount++; $display("FAIL satneg_y%0d: got %h want ffff8000", k, wrData[k]); end
    end
`ifdef RESIDU_OVF_FLAG_EN
    cmpCount++; if (overflow !== 1'b0) begin errCount++; $display("FAIL satneg_overflow_cleared: got %b want 0", overflow); end
`endif
    $display("saturation negative: y[0]=%h", wrData[0]);

    // Gain 2 in Q12: the L_shl by 3 saturates for |x| >= 16384
    loadA(180, '{8192, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 40; i++) setW(400 + i, (i % 3 == 0) ? 20000 : ((i % 3 == 1) ? -20000 : 100));
    doRun(180, 400, 700, 0, 0);
    for (int k = 0; k < 40; k++) begin
      e = (k % 3 == 0) ? 32'h0000_7FFF : ((k % 3 == 1) ? 32'hFFFF_8000 : 32'd200);
      cmpCount++; if (wrData[k] !== e) begin errCount++; $display("FAIL shlsat_y%0d: got %h want %h", k, wrData[k], e); end
    end
`ifdef RESIDU_OVF_FLAG_EN
    cmpCount++; if (overflow !== 1'b1) begin errCount++; $display("FAIL shlsat_overflow: got %b want 1", overflow); end
`endif
    $display("saturation shift: y[0..2]=%h %h %h", wrData[0], wrData[1], wrData[2]);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    setupIdentity(100, 300);
    // Extra start during the run and in the done cycle must both be ignored
    doRun(100, 300, 800, 100, 533);
    cmpCount++; if (wrCount !== 40) begin errCount++; $display("FAIL hs_writes: got %0d want 40", wrCount); end
    cmpCount++; if (doneCount !== 1) begin errCount++; $display("FAIL hs_done_pulses: got %0d want 1", doneCount); end
    cmpCount++; if (doneCyc !== 533) begin errCount++; $display("FAIL hs_done_cycle: got %0d want 533", doneCyc); end
    cmpCount++; if (busyErr !== 0) begin errCount++; $display("FAIL hs_busy_window: got %0d bad cycles want 0", busyErr); end
    for (int k = 0; k < 40; k++) begin
      cmpCount++; if (wrCyc[k] !== 25 + 13 * k) begin errCount++; $display("FAIL hs_wcycle%0d: got %0d want %0d", k, wrCyc[k], 25 + 13 * k); end
      cmpCount++; if (wrAddr[k] !== 11'(800 + k)) begin errCount++; $display("FAIL hs_waddr%0d: got %0d want %0d", k, wrAddr[k], 800 + k); end
      e = k - 20;
      cmpCount++; if (wrData[k] !== e) begin errCount++; $display("FAIL hs_y%0d: got %h want %h", k, wrData[k], e); end
    end
    $display("back_to_back: %0d writes, %0d done pulses at cycle %0d", wrCount, doneCount, doneCyc);
  endtask

  task automatic test_reset_mid_run();
    int w;
    logic [31:0] e;
    setupIdentity(100, 300);
    @(negedge clk);
    aAddr = 11'd100; xAddr = 11'd300; yAddr = 11'd900; start = 1'b1;
    @(posedge clk);
    w = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (memWriteEn === 1'b1) w++;
    end
    reset = 1'b0;
    #1;
    cmpCount++; if (w !== 14) begin errCount++; $display("FAIL abort_writes_before: got %0d want 14", w); end
    cmpCount++; if (memReadAddr !== 11'd0) begin errCount++; $display("FAIL abort_memReadAddr: got %0d want 0", memReadAddr); end
    cmpCount++; if (memWriteAddr !== 11'd0) begin errCount++; $display("FAIL abort_memWriteAddr: got %0d want 0", memWriteAddr); end
    cmpCount++; if (memOut !== 32'd0) begin errCount++; $display("FAIL abort_memOut: got %h want 0", memOut); end
    cmpCount++; if (memWriteEn !== 1'b0) begin errCount++; $display("FAIL abort_memWriteEn: got %b want 0", memWriteEn); end
    cmpCount++; if (busy !== 1'b0) begin errCount++; $display("FAIL abort_busy: got %b want 0", busy); end
    cmpCount++; if (done !== 1'b0) begin errCount++; $display("FAIL abort_done: got %b want 0", done); end
    w = 0;
    repeat (3) begin
      @(negedge clk);
      if (memWriteEn !== 1'b0) w++;
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (memWriteEn !== 1'b0 || busy !== 1'b0) w++;
    end
    cmpCount++; if (w !== 0) begin errCount++; $display("FAIL abort_quiet: got %0d active cycles want 0", w); end
    doRun(100, 300, 900, 0, 0);
    cmpCount++; if (wrCount !== 40) begin errCount++; $display("FAIL rerun_writes: got %0d want 40", wrCount); end
    cmpCount++; if (doneCyc !== 533) begin errCount++; $display("FAIL rerun_done_cycle: got %0d want 533", doneCyc); end
    for (int k = 0; k < 40; k++) begin
      e = k - 20;
      cmpCount++; if (wrData[k] !== e) begin errCount++; $display("FAIL rerun_y%0d: got %h want %h", k, wrData[k], e); end
    end
    $display("reset_mid_run: aborted at cycle 200, rerun done at cycle %0d", doneCyc);
  endtask

  task automatic test_addr_wrap();
    // y(n) = x(n) - x(n-10) with x(n) = 3n: history lives at 2..0 and 2047..2041
    loadA(1000, '{4096, 0, 0, 0, 0, 0, 0, 0, 0, 0, -4096});
    for (int n = -10; n < 40; n++) setW(3 + n, 3 * n);
    doRun(1000, 3, 1500, 0, 0);
    cmpCount++; if (wrCount !== 40) begin errCount++; $display("FAIL wrap_writes: got %0d want 40", wrCount); end
    for (int k = 0; k < 40; k++) begin
      cmpCount++; if (wrData[k] !== 32'd30) begin errCount++; $display("FAIL wrap_y%0d: got %h want 0000001e", k, wrData[k]); end
    end
    $display("addr_wrap: %0d writes, y[0]=%h y[39]=%h", wrCount, wrData[0], wrData[39]);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 32'h0;
    test_reset();
    test_identity();
    test_difference();
    test_saturation();
    test_back_to_back();
    test_reset_mid_run();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
